// File: rtl/timer_pkg.sv
// Shared types and constants for the interval-timer controller.
// Pure declarations; no state.
package timer_pkg;

  localparam int COUNT_W = 8;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: step_o pulses combinationally on the enabled cycle where the
// divider has reached limit_i, so one step occurs every limit_i+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] limit_i,
  output logic                  step_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign step_o = enable_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer controller: IDLE/RUN/HOLD FSM gating a prescaled 8-bit up-counter.
// All outputs registered; first tick (N+1)(P+1) edges after the start edge.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  hold_i,
  input  logic                  mode_i,
  input  logic [COUNT_W-1:0]    period_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  irq_clr_i,
  output logic                  busy_o,
  output logic [COUNT_W-1:0]    count_o,
  output logic                  tick_o,
  output logic                  done_o,
  output logic                  irq_o
);

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [COUNT_W-1:0]    period_q, period_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  mode_q, mode_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic                  irq_q, irq_d;

  logic presc_clr;
  logic presc_en;
  logic step;

  // HOLD with hold released advances on that same edge, so held cycles add
  // exactly one edge each to the tick time.
  assign presc_en  = is_busy(state_q) && !stop_i && !hold_i;
  assign presc_clr = (state_q == ST_IDLE) && start_i && !stop_i;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (presc_clr),
    .enable_i (presc_en),
    .limit_i  (prescale_q),
    .step_o   (step)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    irq_d      = irq_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          mode_d     = mode_i;
          period_d   = period_i;
          prescale_d = prescale_i;
          count_d    = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (hold_i) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          if (step) begin
            if (count_q == period_q) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              count_d = count_q + COUNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A coincident tick overrides the clear.
    if (irq_clr_i) begin
      irq_d = 1'b0;
    end
    if (tick_d) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
    end
  end

  assign busy_o  = is_busy(state_q);
  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected outputs queued per driven edge, popped after it.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold, mode, irq_clr;
  logic [7:0] period;
  logic [7:0] prescale;
  logic       busy, tick, done, irq;
  logic [7:0] count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       busy;
    logic       tick;
    logic       done;
    logic       irq;
  } exp_t;

  exp_t sb[$];

  timer_ctrl #(.PRESCALE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .stop_i     (stop),
    .hold_i     (hold),
    .mode_i     (mode),
    .period_i   (period),
    .prescale_i (prescale),
    .irq_clr_i  (irq_clr),
    .busy_o     (busy),
    .count_o    (count),
    .tick_o     (tick),
    .done_o     (done),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] c, input logic b,
                      input logic t, input logic d, input logic i);
    exp_t e;
    e.tag = tag; e.cnt = c; e.busy = b; e.tick = t; e.done = d; e.irq = i;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".count"}, count, e.cnt);
    chk({e.tag, ".busy"}, {7'b0, busy}, {7'b0, e.busy});
    chk({e.tag, ".tick"}, {7'b0, tick}, {7'b0, e.tick});
    chk({e.tag, ".done"}, {7'b0, done}, {7'b0, e.done});
    chk({e.tag, ".irq"},  {7'b0, irq},  {7'b0, e.irq});
  endtask

  // Queue the outputs expected after the next rising edge, then sample #1 past it.
  task automatic go(input string tag, input logic [7:0] c, input logic b,
                    input logic t, input logic d, input logic i);
    push(tag, c, b, t, d, i);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    logic irq_m;
    logic t;

    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
    irq_clr = 1'b0; period = 8'd0; prescale = 8'd0;

    #2;
    push("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    go("idle0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-shot, P=0, N=3
    mode = 1'b0; period = 8'd3; prescale = 8'd0; start = 1'b1;
    go("os_e0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) go($sformatf("os_e%0d", k), 8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    go("os_e4", 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    go("os_e5", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_clr = 1'b1;
    go("irq_clr_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    irq_clr = 1'b0;

    // Periodic, P=1, N=2, with irq set/clear collision at the edge-12 tick
    mode = 1'b1; period = 8'd2; prescale = 8'd1; start = 1'b1;
    go("per_e0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    irq_m = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      irq_clr = (k == 12) || (k == 13);
      t = ((k % 6) == 0);
      irq_m = t ? 1'b1 : (irq_clr ? 1'b0 : irq_m);
      go($sformatf("per_e%0d", k), 8'((k / 2) % 3), 1'b1, t, 1'b0, irq_m);
    end
    irq_clr = 1'b0;

    // Asynchronous reset in the middle of a periodic run
    #2;
    rst = 1'b1;
    #1;
    push("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    go("rst_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold for three edges, then an ignored start during RUN
    mode = 1'b0; period = 8'd5; prescale = 8'd0; start = 1'b1;
    go("hold_e0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    go("hold_e1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    go("hold_e2", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 3; k <= 5; k++) go($sformatf("hold_e%0d", k), 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    hold = 1'b0;
    go("hold_e6", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1; mode = 1'b1; period = 8'd1; prescale = 8'd3;
    go("hold_e7", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    go("hold_e8", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    go("hold_e9", 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    go("hold_e10", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stop mid-run, then start blocked by a concurrent stop
    mode = 1'b1; period = 8'd4; prescale = 8'd0; start = 1'b1; irq_clr = 1'b1;
    go("stop_e0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0; irq_clr = 1'b0;
    for (int k = 1; k <= 3; k++) go($sformatf("stop_e%0d", k), 8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    go("stop_e4", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    go("stop_start", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    go("stop_idle", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // N=0: a tick on every step; P=2 gives a step every third edge
    mode = 1'b1; period = 8'd0; prescale = 8'd2; start = 1'b1;
    go("n0_e0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    irq_m = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      t = ((k % 3) == 0);
      if (t) irq_m = 1'b1;
      go($sformatf("n0_e%0d", k), 8'd0, 1'b1, t, 1'b0, irq_m);
    end
    stop = 1'b1;
    go("n0_stop", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;

    if (sb.size() != 0) begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable interval-timer controller that sequences an 8-bit up-counter through a prescaled, start/stop/hold-controlled count cycle. It runs in one-shot or periodic mode and produces tick, done and sticky-interrupt outputs for the CPU-side peripheral logic. It sits between the bus/register interface, which drives start/stop/config, and the counter datapath that it gates.

## Interface
- PRESCALE_W, 8, prescaler width; each count step occurs every prescale+1 clocks
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a count cycle; honoured only in IDLE
- stop  in  1  abort; priority over start/hold
- hold  in  1  level; freezes prescaler and count while high in RUN
- mode  in  1  0 = one-shot, 1 = periodic; sampled with start
- period  in  8  terminal count N; sampled with start
- prescale  in  PRESCALE_W  divider P; sampled with start
- irq_clr  in  1  clears irq
- busy  out  1  high in RUN or HOLD
- count  out  8  current count value
- tick  out  1  one-cycle pulse at terminal count
- done  out  1  one-cycle pulse at one-shot completion
- irq  out  1  sticky, set by tick

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: start=1 and stop=0 latches mode/period/prescale into shadow regs, clears count and prescaler, then goes to RUN. Otherwise stays in IDLE; count holds its last value.
- RUN: the prescaler increments each cycle. When prescaler==P_q it clears and issues a step.
- Step with count≠N_q: count+1.
- Step with count==N_q: count<=0, tick<=1. In one-shot mode done<=1 and next state is IDLE; in periodic mode the state stays RUN.
- N=0 gives a tick on every step. P=0 gives a step every cycle.
- RUN with hold=1 goes to HOLD. No prescaler/count change on that edge.
- HOLD: everything is frozen. hold=0 returns to RUN.
- stop=1 in RUN or HOLD goes to IDLE next edge, with no tick or done; count keeps its value.
- start in RUN/HOLD is ignored. Reconfiguring requires stop, then start.
- Same-edge priority: stop > hold > step.
- irq <= 1 on any tick. irq_clr clears it. If set and clear coincide, set wins.
- Widths: count never exceeds N_q, so no 8-bit wrap beyond N_q. The prescaler never exceeds P_q.

## Timing
- Reset values: state IDLE; count 0, busy 0, tick 0, done 0, irq 0; shadow regs 0; prescaler 0.
- Reset takes effect immediately, including mid-RUN or mid-HOLD.
- Start is sampled at edge 0. busy is high after edge 0.
- First tick is visible after edge (N+1)(P+1) (hold cycles excluded) for exactly one cycle. Periodic ticks recur every (N+1)(P+1) edges.
- One-shot: done coincides with tick, and busy falls on the same edge.
- count updates one edge after the step condition is sampled.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- timer_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1;
  - the localparam for count width 8.
- Sub-module tick_prescaler (PRESCALE_W):
  - inputs clk, rst, clear, enable, limit;
  - output step;
  - instantiated once.
- Count register, FSM and irq live in timer_ctrl.

## Test plan
- Reset: assert rst mid-periodic-RUN, off-edge → busy, count, tick, done and irq are 0 immediately; state IDLE after release.
- One-shot, P=0, N=3, start at edge 0 → count 1,2,3 after edges 1–3; tick=done=1 after edge 4 only; busy 0 and irq 1 after edge 4.
- Periodic, P=1, N=2 → ticks after edges 6, 12, 18; count sequence 0,0,1,1,2,2,0; busy stays 1.
- Hold: one-shot P=0, N=5; hold high for 3 cycles starting after edge 2 → count frozen at 2; tick shifted to after edge 9. A start pulse during RUN is ignored, with no reload of config.
- Stop: periodic N=4; stop after edge 3 → IDLE, count holds 3, no tick or done. start with stop on the same edge → remains IDLE.
- irq: tick and irq_clr on the same edge → irq stays 1; irq_clr alone on the next edge → irq 0.
